matrix_scan: RTL and testbench
==============================

MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 The block SHALL have parameter N_COL, default 5, number of scanned columns.
REQ-002 The block SHALL have parameter N_ROW, default 7, number of sensed rows.
REQ-003 The block SHALL have parameter DEBOUNCE, default 3, number of identical consecutive frames required to accept a change (legal range 2..7).
REQ-004 The block SHALL have port clk_191hz, input, 1 bit, the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port col_drv, output, N_COL bits, one-hot active-high column drive; bit c drives column c.
REQ-007 The block SHALL have port row_in, input, N_ROW bits, active-high sensed rows; row_in[N_ROW-1-r] is row r, so row 0 is the MSB.
REQ-008 The block SHALL have port key_valid, output, 1 bit, meaning an event is presented.
REQ-009 The block SHALL have port key_code, output, 6 bits, key index col*N_ROW+row, range 0..34.
REQ-010 The block SHALL have port key_make, output, 1 bit: 1 = press, 0 = release.
REQ-011 The block SHALL have port key_ack, input, 1 bit, consumer acceptance of the presented event.
REQ-012 The block SHALL have port overrun, output, 1 bit, sticky flag meaning a debounced update was deferred.

Function
REQ-013 The FSM SHALL have states S_DRIVE, S_SAMPLE and S_EVAL, with col_idx counting 0..N_COL-1.
REQ-014 In S_DRIVE and S_SAMPLE, col_drv SHALL equal one-hot(col_idx); in S_EVAL, col_drv SHALL be 0.
REQ-015 S_DRIVE SHALL always go to S_SAMPLE, giving one settle cycle.
REQ-016 S_SAMPLE SHALL capture row_in into raw_frame for column col_idx, then go to S_DRIVE with col_idx+1, or to S_EVAL when col_idx = N_COL-1.
REQ-017 S_EVAL SHALL go to S_DRIVE with col_idx = 0, giving a frame period of 2*N_COL+1 = 11 cycles.
REQ-018 In S_EVAL, stable_cnt SHALL become min(stable_cnt+1, DEBOUNCE) if raw_frame = last_frame, otherwise 1; last_frame SHALL then load raw_frame.
REQ-019 In S_EVAL, if the new stable_cnt = DEBOUNCE, raw_frame differs from deb_frame and pending = 0, then pending SHALL load raw_frame XOR deb_frame and deb_frame SHALL load raw_frame.
REQ-020 If the condition of REQ-019 holds except that pending is non-zero, the update SHALL be deferred (re-evaluated every frame, no event lost) and overrun SHALL be set.
REQ-021 When key_valid = 0 and pending is non-zero, key_valid SHALL rise on the next cycle, with key_code = lowest set index of pending and key_make = the deb_frame bit at that index.
REQ-022 key_valid, key_code and key_make SHALL hold stable until a cycle with key_valid = 1 and key_ack = 1.
REQ-023 On that acknowledge cycle, the pending bit SHALL clear and key_valid SHALL be 0 for at least one following cycle.
REQ-024 key_ack while key_valid = 0 SHALL be ignored.
REQ-025 A simultaneous pending load and acknowledge cannot occur because REQ-019 requires pending = 0; no additional arbitration SHALL be added.
REQ-026 Any set of simultaneous changes SHALL be delivered as separate events in ascending key_code order.

Reset
REQ-027 While rst = 0, col_drv = 0, key_valid = 0, key_code = 0, key_make = 0 and overrun = 0 SHALL hold, and the state SHALL be S_DRIVE with col_idx = 0.
REQ-028 While rst = 0, raw_frame, last_frame, deb_frame and pending SHALL be 0 and stable_cnt SHALL be 0.
REQ-029 Reset asserted mid-frame or mid-event SHALL take effect asynchronously and discard any presented event.
REQ-030 The first cycle after release SHALL drive col_drv = 5'b00001.
REQ-031 overrun SHALL be cleared only by reset.

Structure
REQ-032 The shared package matrix_pkg SHALL hold N_COL, N_ROW, N_KEYS = 35, KEY_W = 6 and the FSM state encoding.
REQ-033 A sub-module key_prio_enc SHALL be used, with a 35-bit input, a 6-bit lowest-set index and a found flag.

Verification
REQ-034 Reset: hold rst = 0 for 5 cycles, then release -> col_drv = 0 and key_valid = 0 during reset; col_drv = 00001, 00010 on the next two DRIVE phases.
REQ-035 Press: row_in[3] = 1 whenever col_drv[2] = 1 (col 2, row 3), from frame start -> key_valid = 1 with key_code = 17, key_make = 1, one cycle after the 3rd S_EVAL (cycle 34).
REQ-036 Glitch: the same press for only 2 frames, then released -> key_valid stays 0.
REQ-037 Multi-key with backpressure: keys 0 and 34 pressed together, key_ack held 0 for 100 cycles -> key_code = 0 held stable; after ack, a gap of at least one cycle, then key_code = 34.
REQ-038 Overrun: key 5 released while the key-0 event is unacknowledged and stable for 3 frames -> overrun = 1; after the ack, event key_code = 5 with key_make = 0.
REQ-039 Reset mid-event: rst = 0 while key_valid = 1 -> key_valid = 0 immediately; no event after release until new stable input.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and FSM encoding for the key-matrix scanner.
package matrix_pkg;
  localparam int N_COL  = 5;
  localparam int N_ROW  = 7;
  localparam int N_KEYS = N_COL * N_ROW;
  localparam int KEY_W  = 6;

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_SAMPLE = 2'd1,
    S_EVAL   = 2'd2
  } state_e;
endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next key event.
module key_prio_enc
  import matrix_pkg::*;
#(
  parameter int W = N_KEYS
) (
  input  logic [W-1:0]     vec_i,
  output logic [KEY_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = KEY_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// Column-scanned key matrix with frame debounce and a one-event handshake queue.
// state    | meaning
// S_DRIVE  | drive column col_idx, settle cycle
// S_SAMPLE | capture row_in for column col_idx
// S_EVAL   | debounce the completed frame, columns released
module matrix_scan #(
  parameter int N_COL    = matrix_pkg::N_COL,
  parameter int N_ROW    = matrix_pkg::N_ROW,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk_191hz,
  input  logic             rst,
  output logic [N_COL-1:0] col_drv,
  input  logic [N_ROW-1:0] row_in,
  output logic             key_valid,
  output logic [5:0]       key_code,
  output logic             key_make,
  input  logic             key_ack,
  output logic             overrun
);
  import matrix_pkg::*;

  localparam int NK = N_COL * N_ROW;
  localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam logic [2:0] DEB = 3'(DEBOUNCE);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic [NK-1:0]     raw_q, raw_d, last_q, last_d, deb_q, deb_d, pend_q, pend_d;
  logic [2:0]        cnt_q, cnt_d, cnt_new;
  logic              valid_q, valid_d, make_q, make_d, ovr_q, ovr_d;
  logic [KEY_W-1:0]  code_q, code_d;
  logic [KEY_W-1:0]  enc_idx;
  logic              enc_found;

  key_prio_enc #(.W(NK)) u_enc (
    .vec_i   (pend_q),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    raw_d     = raw_q;
    last_d    = last_q;
    deb_d     = deb_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    valid_d   = valid_q;
    code_d    = code_q;
    make_d    = make_q;
    cnt_new   = (raw_q == last_q) ? ((cnt_q >= DEB) ? DEB : cnt_q + 3'd1) : 3'd1;

    case (state_q)
      S_DRIVE: state_d = S_SAMPLE;
      S_SAMPLE: begin
        // row 0 arrives on the MSB of row_in
        for (int c = 0; c < N_COL; c++) begin
          if (col_idx_q == CW'(c)) begin
            for (int r = 0; r < N_ROW; r++) raw_d[c*N_ROW + r] = row_in[N_ROW-1-r];
          end
        end
        if (col_idx_q == CW'(N_COL - 1)) state_d = S_EVAL;
        else begin
          state_d   = S_DRIVE;
          col_idx_d = col_idx_q + CW'(1);
        end
      end
      S_EVAL: begin
        cnt_d  = cnt_new;
        last_d = raw_q;
        // a stable change waits in place while an earlier batch is still draining
        if (cnt_new == DEB && raw_q != deb_q) begin
          if (pend_q == '0) begin
            pend_d = raw_q ^ deb_q;
            deb_d  = raw_q;
          end else begin
            ovr_d = 1'b1;
          end
        end
        state_d   = S_DRIVE;
        col_idx_d = '0;
      end
      default: begin
        state_d   = S_DRIVE;
        col_idx_d = '0;
      end
    endcase

    if (valid_q && key_ack) begin
      valid_d        = 1'b0;
      pend_d[code_q] = 1'b0;
    end else if (!valid_q && enc_found) begin
      valid_d = 1'b1;
      code_d  = enc_idx;
      make_d  = deb_q[enc_idx];
    end
  end

  always_ff @(posedge clk_191hz or negedge rst) begin
    if (!rst) begin
      state_q   <= S_DRIVE;
      col_idx_q <= '0;
      raw_q     <= '0;
      last_q    <= '0;
      deb_q     <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      make_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      raw_q     <= raw_d;
      last_q    <= last_d;
      deb_q     <= deb_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      make_q    <= make_d;
    end
  end

  // gated by rst so the columns are released during reset, not just after the next edge
  assign col_drv   = (rst && state_q != S_EVAL) ? (N_COL'(1) << col_idx_q) : '0;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_make  = make_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: a key-matrix model drives row_in, events are scoreboarded.
module tb_matrix_scan;

  typedef struct packed {
    logic [5:0] code;
    logic       make;
  } evt_t;

  logic       clk_191hz = 1'b0;
  logic       rst;
  logic [4:0] col_drv;
  logic [6:0] row_in;
  logic       key_valid;
  logic [5:0] key_code;
  logic       key_make;
  logic       key_ack;
  logic       overrun;
  logic [34:0] keys;

  int   n_cmp = 0;
  int   n_err = 0;
  evt_t sb[$];

  matrix_scan dut (
    .clk_191hz (clk_191hz),
    .rst       (rst),
    .col_drv   (col_drv),
    .row_in    (row_in),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_make  (key_make),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  always #5 clk_191hz = ~clk_191hz;

  // pressed key k = col*7+row shorts driven column col onto row_in[6-row]
  always_comb begin
    row_in = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        if (col_drv[c] && keys[c*7+r]) row_in[6-r] = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_sync();
    int n = 0;
    do begin
      @(negedge clk_191hz);
      n++;
    end while (col_drv != 5'd0 && n < 30);
    if (n >= 30) check("frame_sync_timeout", {59'd0, col_drv}, 64'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk_191hz);
      n++;
    end
    check("wait_valid", {63'd0, key_valid}, 64'd1);
  endtask

  task automatic consume(input int budget);
    evt_t e;
    wait_valid(budget);
    if (key_valid) begin
      check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("evt_code", {58'd0, key_code}, {58'd0, e.code});
        check("evt_make", {63'd0, key_make}, {63'd0, e.make});
      end
      key_ack = 1'b1;
      @(negedge clk_191hz);
      key_ack = 1'b0;
      check("ack_gap", {63'd0, key_valid}, 64'd0);
    end
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_191hz);
      if (key_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int bad;
    rst     = 1'b0;
    key_ack = 1'b0;
    keys    = '0;

    // reset, with key 17 (col 2, row 3) already held so the press starts with frame 1
    keys[17] = 1'b1;
    repeat (5) @(negedge clk_191hz);
    check("rst_col_drv", {59'd0, col_drv}, 64'd0);
    check("rst_valid", {63'd0, key_valid}, 64'd0);
    check("rst_code", {58'd0, key_code}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    sb.push_back('{code: 6'd17, make: 1'b1});
    rst = 1'b1;
    #1;
    check("first_drive", {59'd0, col_drv}, 64'd1);
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk_191hz);
      if (e == 1)  check("drive_col0", {59'd0, col_drv}, 64'h01);
      if (e == 2)  check("drive_col1", {59'd0, col_drv}, 64'h02);
      if (e == 10) check("eval_no_drive", {59'd0, col_drv}, 64'h00);
      if (e == 33) check("press_not_early", {63'd0, key_valid}, 64'd0);
      if (e == 34) check("press_cycle34", {63'd0, key_valid}, 64'd1);
    end
    consume(5);

    // release key 17, then a two-frame glitch that must be rejected
    frame_sync();
    keys[17] = 1'b0;
    sb.push_back('{code: 6'd17, make: 1'b0});
    consume(80);
    frame_sync();
    keys[17] = 1'b1;
    frame_sync();
    frame_sync();
    keys[17] = 1'b0;
    watch_quiet("glitch_no_event", 66);

    // keys 0 and 34 together, consumer stalls for 100 cycles
    frame_sync();
    keys[0]  = 1'b1;
    keys[34] = 1'b1;
    sb.push_back('{code: 6'd0, make: 1'b1});
    sb.push_back('{code: 6'd34, make: 1'b1});
    wait_valid(80);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_191hz);
      if (!key_valid || key_code != 6'd0 || !key_make) bad++;
    end
    check("backpressure_hold", 64'(bad), 64'd0);
    consume(5);
    consume(5);
    check("no_overrun_yet", {63'd0, overrun}, 64'd0);

    // key 5 pressed and consumed, then key 0 release left unacknowledged
    frame_sync();
    keys[5] = 1'b1;
    sb.push_back('{code: 6'd5, make: 1'b1});
    consume(80);
    frame_sync();
    keys[0] = 1'b0;
    sb.push_back('{code: 6'd0, make: 1'b0});
    wait_valid(80);
    frame_sync();
    keys[5] = 1'b0;
    sb.push_back('{code: 6'd5, make: 1'b0});
    repeat (4) frame_sync();
    check("overrun_set", {63'd0, overrun}, 64'd1);
    check("stalled_code", {58'd0, key_code}, 64'd0);
    consume(5);
    consume(80);
    check("overrun_sticky", {63'd0, overrun}, 64'd1);

    // reset while the key 34 release is presented
    frame_sync();
    keys[34] = 1'b0;
    sb.push_back('{code: 6'd34, make: 1'b0});
    wait_valid(80);
    @(negedge clk_191hz);
    rst = 1'b0;
    #1;
    check("midrst_valid", {63'd0, key_valid}, 64'd0);
    check("midrst_overrun", {63'd0, overrun}, 64'd0);
    check("midrst_col_drv", {59'd0, col_drv}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk_191hz);
    rst = 1'b1;
    watch_quiet("post_rst_quiet", 66);
    frame_sync();
    keys[12] = 1'b1;
    sb.push_back('{code: 6'd12, make: 1'b1});
    consume(80);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
